// File: rtl/cdc_rx_buffer.sv
// Burst-forming read-side buffer: collects words from a clock-domain crossing and
// releases them as contiguous bursts. Optional FILL timeout: CDC_RX_BUFFER_TIMEOUT_EN.
module cdc_rx_buffer #(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 8,
  parameter int THRESHOLD      = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_cg,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_wvalid,
  output logic                         o_wready,
  output logic [WIDTH-1:0]             o_rdata,
  output logic                         o_rvalid,
  input  logic                         i_rready,
  output logic [$clog2(DEPTH+1)-1:0]   o_nEntries,
  output logic                         o_draining
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] THR_CNT  = CW'(THRESHOLD);

  if (WIDTH < 1) begin : g_bad_width
    $error("cdc_rx_buffer: WIDTH must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cdc_rx_buffer: DEPTH must be a power of 2 and >= 2");
  end
  if (THRESHOLD < 1 || THRESHOLD > DEPTH) begin : g_bad_thr
    $error("cdc_rx_buffer: THRESHOLD must be in 1..DEPTH");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("cdc_rx_buffer: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_write, do_read;
  logic             tmo_hit;

  assign o_wready   = (o_nEntries != FULL_CNT);
  assign o_rvalid   = (state == DRAIN) && (o_nEntries != '0);
  assign o_draining = (state == DRAIN);
  assign o_rdata    = mem[rptr];
  assign do_write   = o_wready && i_wvalid && i_cg;
  assign do_read    = o_rvalid && i_rready && i_cg;

  // Storage holds no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge i_clk) begin
    if (do_write) mem[wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr       <= '0;
      rptr       <= '0;
      o_nEntries <= '0;
      state      <= FILL;
    end else begin
      if (do_write) wptr <= wptr + AW'(1);
      if (do_read)  rptr <= rptr + AW'(1);
      case ({do_write, do_read})
        2'b10:   o_nEntries <= o_nEntries + CW'(1);
        2'b01:   o_nEntries <= o_nEntries - CW'(1);
        default: o_nEntries <= o_nEntries;
      endcase
      if (i_cg) state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (o_nEntries >= THR_CNT || tmo_hit) state_nxt = DRAIN;
      DRAIN:   if (o_nEntries == CW'(1) && do_read && !do_write) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

`ifdef CDC_RX_BUFFER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt;

  // Counts only while a partial burst sits in FILL; held at zero otherwise.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tmo_cnt <= '0;
    end else if (i_cg) begin
      if (state != FILL || o_nEntries == '0) tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX)          tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_MAX);
`else
  assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_rx_buffer.sv
// Directed self-checking bench for cdc_rx_buffer (default parameters).
module tb_cdc_rx_buffer;

  logic       i_clk = 1'b0;
  logic       i_rstn, i_cg, i_wvalid, i_rready;
  logic [7:0] i_wdata;
  logic       o_wready, o_rvalid, o_draining;
  logic [7:0] o_rdata;
  logic [3:0] o_nEntries;

  int checks   = 0;
  int failures = 0;

  cdc_rx_buffer dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_cg       (i_cg),
    .i_wdata    (i_wdata),
    .i_wvalid   (i_wvalid),
    .o_wready   (o_wready),
    .o_rdata    (o_rdata),
    .o_rvalid   (o_rvalid),
    .i_rready   (i_rready),
    .o_nEntries (o_nEntries),
    .o_draining (o_draining)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rstn = 1'b1; i_cg = 1'b1; i_wvalid = 1'b0; i_rready = 1'b0; i_wdata = '0;
    #2 i_rstn = 1'b0;
    #1;
    checks++; if (o_nEntries !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", o_nEntries); end
    checks++; if (o_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", o_rvalid); end
    checks++; if (o_wready !== 1'b1) begin failures++; $display("FAIL reset_wready got=%b exp=1", o_wready); end
    checks++; if (o_draining !== 1'b0) begin failures++; $display("FAIL reset_draining got=%b exp=0", o_draining); end
    step(); step();
    i_rstn = 1'b1;
    step();
    checks++; if (o_nEntries !== 4'd0 || o_wready !== 1'b1) begin failures++; $display("FAIL reset_release cnt=%0d wready=%b exp cnt=0 wready=1", o_nEntries, o_wready); end
  endtask

  task automatic test_threshold();
    logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    i_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_wvalid = 1'b1; i_wdata = exp_d[i];
      step();
    end
    i_wvalid = 1'b0;
    step(); step();
    checks++; if (o_rvalid !== 1'b0) begin failures++; $display("FAIL thr_below_rvalid got=%b exp=0", o_rvalid); end
    checks++; if (o_nEntries !== 4'd3) begin failures++; $display("FAIL thr_below_cnt got=%0d exp=3", o_nEntries); end
    i_wvalid = 1'b1; i_wdata = exp_d[3];
    step();
    i_wvalid = 1'b0;
    checks++; if (o_rvalid !== 1'b0) begin failures++; $display("FAIL thr_lat1_rvalid got=%b exp=0", o_rvalid); end
    step();
    checks++; if (o_rvalid !== 1'b1 || o_draining !== 1'b1) begin failures++; $display("FAIL thr_lat2 rvalid=%b draining=%b exp 1 1", o_rvalid, o_draining); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (o_rvalid !== 1'b1 || o_rdata !== exp_d[i]) begin failures++; $display("FAIL thr_read%0d rvalid=%b data=%h exp 1 %h", i, o_rvalid, o_rdata, exp_d[i]); end
      step();
    end
    checks++; if (o_draining !== 1'b0 || o_nEntries !== 4'd0 || o_rvalid !== 1'b0) begin failures++; $display("FAIL thr_end draining=%b cnt=%0d rvalid=%b exp 0 0 0", o_draining, o_nEntries, o_rvalid); end
  endtask

  task automatic test_full();
    i_rready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      i_wvalid = 1'b1; i_wdata = 8'h81 + 8'(i);
      step();
    end
    checks++; if (o_wready !== 1'b0) begin failures++; $display("FAIL full_wready got=%b exp=0", o_wready); end
    checks++; if (o_nEntries !== 4'd8) begin failures++; $display("FAIL full_cnt got=%0d exp=8", o_nEntries); end
    i_wdata = 8'hEE;
    step();
    checks++; if (o_nEntries !== 4'd8) begin failures++; $display("FAIL full_refuse_cnt got=%0d exp=8", o_nEntries); end
    // Full with simultaneous read: write must still be refused.
    i_rready = 1'b1;
    step();
    i_wvalid = 1'b0;
    checks++; if (o_nEntries !== 4'd7) begin failures++; $display("FAIL full_rdwr_cnt got=%0d exp=7", o_nEntries); end
    checks++; if (o_wready !== 1'b1) begin failures++; $display("FAIL full_wready_after got=%b exp=1", o_wready); end
    for (int i = 1; i < 8; i++) begin
      checks++; if (o_rdata !== 8'h81 + 8'(i)) begin failures++; $display("FAIL full_read%0d got=%h exp=%h", i, o_rdata, 8'h81 + 8'(i)); end
      step();
    end
    checks++; if (o_nEntries !== 4'd0 || o_draining !== 1'b0) begin failures++; $display("FAIL full_end cnt=%0d draining=%b exp 0 0", o_nEntries, o_draining); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_v;
    i_rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_wvalid = 1'b1; i_wdata = 8'hA0 + 8'(i);
      step();
    end
    i_wvalid = 1'b0;
    step();
    i_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (o_rdata !== 8'hA0 + 8'(i)) begin failures++; $display("FAIL b2b_pre%0d got=%h exp=%h", i, o_rdata, 8'hA0 + 8'(i)); end
      step();
    end
    checks++; if (o_nEntries !== 4'd1 || o_draining !== 1'b1) begin failures++; $display("FAIL b2b_one cnt=%0d draining=%b exp 1 1", o_nEntries, o_draining); end
    for (int i = 0; i < 20; i++) begin
      exp_v = (i == 0) ? 8'hA3 : 8'hB0 + 8'(i - 1);
      i_wvalid = 1'b1; i_wdata = 8'hB0 + 8'(i);
      checks++; if (o_rdata !== exp_v) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", i, o_rdata, exp_v); end
      step();
      checks++; if (o_nEntries !== 4'd1 || o_draining !== 1'b1) begin failures++; $display("FAIL b2b_state%0d cnt=%0d draining=%b exp 1 1", i, o_nEntries, o_draining); end
    end
    i_wvalid = 1'b0;
    checks++; if (o_rdata !== 8'hC3) begin failures++; $display("FAIL b2b_last got=%h exp=c3", o_rdata); end
    step();
    checks++; if (o_draining !== 1'b0 || o_nEntries !== 4'd0) begin failures++; $display("FAIL b2b_end draining=%b cnt=%0d exp 0 0", o_draining, o_nEntries); end
  endtask

  task automatic test_reset_mid_burst();
    i_rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_wvalid = 1'b1; i_wdata = 8'h50 + 8'(i);
      step();
    end
    i_wvalid = 1'b0;
    checks++; if (o_nEntries !== 4'd5 || o_draining !== 1'b1) begin failures++; $display("FAIL mid_setup cnt=%0d draining=%b exp 5 1", o_nEntries, o_draining); end
    #3 i_rstn = 1'b0;
    #1;
    checks++; if (o_rvalid !== 1'b0 || o_nEntries !== 4'd0 || o_wready !== 1'b1 || o_draining !== 1'b0) begin
      failures++; $display("FAIL mid_reset rvalid=%b cnt=%0d wready=%b draining=%b exp 0 0 1 0", o_rvalid, o_nEntries, o_wready, o_draining);
    end
    #2 i_rstn = 1'b1;
    step();
    i_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_wvalid = 1'b1; i_wdata = 8'hC0 + 8'(i);
      step();
    end
    i_wvalid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (o_rvalid !== 1'b1 || o_rdata !== 8'hC0 + 8'(i)) begin failures++; $display("FAIL mid_read%0d rvalid=%b data=%h exp 1 %h", i, o_rvalid, o_rdata, 8'hC0 + 8'(i)); end
      step();
    end
    checks++; if (o_nEntries !== 4'd0 || o_draining !== 1'b0) begin failures++; $display("FAIL mid_end cnt=%0d draining=%b exp 0 0", o_nEntries, o_draining); end
  endtask

  task automatic test_clock_gate();
    i_rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_wvalid = 1'b1; i_wdata = 8'hD0 + 8'(i);
      step();
    end
    i_wvalid = 1'b0;
    step();
    i_cg = 1'b0; i_wvalid = 1'b1; i_rready = 1'b1; i_wdata = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (o_nEntries !== 4'd4 || o_draining !== 1'b1 || o_rdata !== 8'hD0) begin
        failures++; $display("FAIL cg_hold%0d cnt=%0d draining=%b data=%h exp 4 1 d0", i, o_nEntries, o_draining, o_rdata);
      end
    end
    i_cg = 1'b1; i_wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (o_rdata !== 8'hD0 + 8'(i)) begin failures++; $display("FAIL cg_read%0d got=%h exp=%h", i, o_rdata, 8'hD0 + 8'(i)); end
      step();
    end
    checks++; if (o_nEntries !== 4'd0 || o_draining !== 1'b0) begin failures++; $display("FAIL cg_end cnt=%0d draining=%b exp 0 0", o_nEntries, o_draining); end
  endtask

`ifdef CDC_RX_BUFFER_TIMEOUT_EN
  task automatic test_timeout();
    i_rready = 1'b0;
    i_wvalid = 1'b1; i_wdata = 8'hA5;
    step();
    i_wvalid = 1'b0;
    repeat (15) step();
    checks++; if (o_rvalid !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", o_rvalid); end
    step();
    checks++; if (o_rvalid !== 1'b1 || o_rdata !== 8'hA5) begin failures++; $display("FAIL tmo_fire rvalid=%b data=%h exp 1 a5", o_rvalid, o_rdata); end
    i_rready = 1'b1;
    step();
    checks++; if (o_draining !== 1'b0 || o_nEntries !== 4'd0) begin failures++; $display("FAIL tmo_end draining=%b cnt=%0d exp 0 0", o_draining, o_nEntries); end
  endtask
`endif

  initial begin
    test_reset();
    test_threshold();
    test_full();
    test_back_to_back();
    test_reset_mid_burst();
    test_clock_gate();
`ifdef CDC_RX_BUFFER_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdc_rx_buffer.md
CDC_RX_BUFFER -- requirements
Module: cdc_rx_buffer

Single-clock burst-forming buffer on the read side of a clock-domain crossing. It drains single words from the crossing and releases them downstream as contiguous bursts.

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter WIDTH, default 8, data width in bits, >= 1.
REQ-003 Parameter DEPTH, default 8, number of entries, a power of 2, >= 2.
REQ-004 Parameter THRESHOLD, default 4, occupancy that starts a burst, 1..DEPTH.
REQ-005 Parameter TIMEOUT_CYCLES, default 15, enabled cycles in FILL before a forced drain, >= 1.
REQ-006 i_clk  input  1  clock; all state updates on rising edge.
REQ-007 i_rstn  input  1  asynchronous active-low reset.
REQ-008 i_cg  input  1  clock gate; when low, no state changes.
REQ-009 i_wdata  input  WIDTH  write data from the crossing.
REQ-010 i_wvalid  input  1  write valid.
REQ-011 o_wready  output  1  write ready.
REQ-012 o_rdata  output  WIDTH  read data, head entry.
REQ-013 o_rvalid  output  1  read valid.
REQ-014 i_rready  input  1  read ready.
REQ-015 o_nEntries  output  $clog2(DEPTH+1)  registered occupancy.
REQ-016 o_draining  output  1  high while the FSM is in DRAIN.

Function
REQ-017 doWrite SHALL be o_wready && i_wvalid && i_cg; doRead SHALL be o_rvalid && i_rready && i_cg.
REQ-018 o_wready SHALL be (o_nEntries != DEPTH) and SHALL NOT depend on i_rready; a full buffer refuses writes even when a read happens in the same cycle.
REQ-019 Write and read pointers SHALL have log2(DEPTH) bits, SHALL increment on doWrite and doRead respectively, and SHALL wrap from DEPTH-1 to 0.
REQ-020 On each cycle, o_nEntries SHALL change by +1 on doWrite only, by -1 on doRead only, and by 0 when both or neither occur.
REQ-021 o_rdata SHALL equal the entry at the read pointer with zero latency; its value is don't-care while o_rvalid is low.
REQ-022 The FSM SHALL have two states, FILL and DRAIN; it SHALL enter FILL on reset.
REQ-023 In FILL, o_rvalid SHALL be 0.
REQ-024 In FILL, the FSM SHALL move to DRAIN on the next enabled edge when o_nEntries >= THRESHOLD.
REQ-025 In DRAIN, o_rvalid SHALL be (o_nEntries != 0).
REQ-026 In DRAIN, the FSM SHALL return to FILL when o_nEntries==1 && doRead && !doWrite.
REQ-027 If a write and a read occur in the same cycle during DRAIN, the FSM SHALL remain in DRAIN.
REQ-028 First write-to-o_rvalid latency SHALL be 2 cycles when THRESHOLD=1 (write, count update, state update).
REQ-029 Once asserted, o_rvalid SHALL stay high until a read occurs or reset.
REQ-030 o_draining SHALL be 1 exactly when the state is DRAIN.

Reset
REQ-031 Asserting i_rstn low SHALL immediately set pointers to 0, o_nEntries=0, state to FILL, o_rvalid=0, o_draining=0, o_wready=1, and the timeout counter to 0.
REQ-032 Reset SHALL discard all stored data, including mid-burst.
REQ-033 Entry storage SHALL be unreset.
REQ-034 Deassertion of i_rstn SHALL be synchronised externally; the block SHALL NOT resynchronise it.

Configuration
REQ-035 The feature macro SHALL be CDC_RX_BUFFER_TIMEOUT_EN.
REQ-036 With CDC_RX_BUFFER_TIMEOUT_EN defined:
- a counter SHALL increment on each enabled cycle in FILL while o_nEntries != 0;
- it SHALL clear on entering FILL or when o_nEntries==0;
- when it reaches TIMEOUT_CYCLES, the FSM SHALL move to DRAIN on the next enabled edge, regardless of THRESHOLD.
REQ-037 Without the macro, no counter logic SHALL exist, and FILL SHALL exit only via REQ-024, so partial bursts below THRESHOLD wait indefinitely.

Verification
REQ-038 Defaults: write 3 words 0x11,0x22,0x33 with i_rready=1 -> o_rvalid stays 0 (timeout off); 4th word 0x44 -> o_rvalid high 2 cycles later; reads return 0x11..0x44 back-to-back; then FILL.
REQ-039 Fill 8 words with i_rready=0 -> o_wready=0, o_nEntries=8; a further i_wvalid is not accepted; one read -> o_wready=1 the next cycle.
REQ-040 In DRAIN with o_nEntries=1, hold i_wvalid=1 and i_rready=1 for 20 cycles -> state stays DRAIN, o_nEntries=1, data order preserved across pointer wrap.
REQ-041 With CDC_RX_BUFFER_TIMEOUT_EN: write 1 word 0xA5 -> o_rvalid rises after 15 enabled FILL cycles plus 1; read returns 0xA5.
REQ-042 Mid-burst (o_nEntries=5, DRAIN), pulse i_rstn low -> o_rvalid=0, o_nEntries=0, o_wready=1 immediately; a subsequent 4-word burst reads correctly.
REQ-043 Hold i_cg=0 with i_wvalid=1 and i_rready=1 for 10 cycles -> o_nEntries, pointers and state unchanged.
